// File: rtl/noc_pkt_pkg.sv
// Shared NoC packet definitions: header field layout, depacketizer states and
// a header field extractor.
package noc_pkt_pkg;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        PAY   = 2'd1,
        DRAIN = 2'd2
    } rx_state_t;

    // Widest header view the extractor works on, and widest single field.
    localparam int HDR_MAX   = 64;
    localparam int FIELD_MAX = 32;

    localparam int DST_X_LSB = 0;
    localparam int LEN_LSB   = 16;
    localparam int LEN_W     = 16;

    function automatic int dst_y_lsb(input int xy_sz);
        return xy_sz;
    endfunction

    function automatic int src_lsb(input int xy_sz);
        return 2 * xy_sz;
    endfunction

    // Pull a w-bit field starting at lsb; w == FIELD_MAX gives an all-ones mask.
    function automatic logic [FIELD_MAX-1:0] hdr_field(input logic [HDR_MAX-1:0] flit,
                                                       input int lsb, input int w);
        logic [FIELD_MAX-1:0] mask;
        mask = (FIELD_MAX'(1) << w) - FIELD_MAX'(1);
        return FIELD_MAX'(flit >> lsb) & mask;
    endfunction

endpackage

// File: rtl/noc_local_rx_depacketizer_if.sv
// AXI-Stream flit bus used on both sides of the local rx depacketizer.
interface noc_local_rx_depacketizer_if #(
    parameter int BW = 32
) ();
    localparam int BWB = BW / 8;

    logic           TVALID;
    logic [BW-1:0]  TDATA;
    logic [BWB-1:0] TKEEP;
    logic           TLAST;
    logic           TREADY;

    modport master (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TKEEP, TLAST, output TREADY);
endinterface

// File: rtl/noc_local_rx_depacketizer.sv
// Strips the NoC header off packets addressed to this tile and forwards the
// payload as AXI-Stream, enforcing the header length against TLAST.
module noc_local_rx_depacketizer
    import noc_pkt_pkg::*;
#(
    parameter int BW    = 32,
    parameter int BWB   = BW / 8,
    parameter int XY_SZ = 3,
    parameter int LEN_W = noc_pkt_pkg::LEN_W,
    parameter int CNT_W = 16
) (
    input  logic                   clk_line,
    input  logic                   clk_line_rst_low,
    input  logic [2*XY_SZ-1:0]     HsrcId,
    noc_local_rx_depacketizer_if.slave  s,
    noc_local_rx_depacketizer_if.master m,
    output logic [2*XY_SZ-1:0]     m_src_id,
    output logic [LEN_W-1:0]       m_len,
    output logic                   err_dst,
    output logic                   err_short,
    output logic                   err_long,
    output logic [CNT_W-1:0]       pkt_ok_cnt
);

    localparam int ID_W = 2 * XY_SZ;

    rx_state_t        state;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] hdr_len;
    logic [ID_W-1:0]  hdr_src;

    logic             out_vld;
    logic             out_last;
    logic [BW-1:0]    out_data;
    logic [BWB-1:0]   out_keep;

    logic [HDR_MAX-1:0] hdr_bits;
    logic [XY_SZ-1:0]   f_dst_x;
    logic [XY_SZ-1:0]   f_dst_y;
    logic [ID_W-1:0]    f_src;
    logic [LEN_W-1:0]   f_len;
    logic               s_rdy;
    logic               s_hs;

    assign hdr_bits = HDR_MAX'(s.TDATA);
    assign f_dst_x  = XY_SZ'(hdr_field(hdr_bits, DST_X_LSB, XY_SZ));
    assign f_dst_y  = XY_SZ'(hdr_field(hdr_bits, dst_y_lsb(XY_SZ), XY_SZ));
    assign f_src    = ID_W'(hdr_field(hdr_bits, src_lsb(XY_SZ), ID_W));
    assign f_len    = LEN_W'(hdr_field(hdr_bits, LEN_LSB, LEN_W));

    // Only PAY writes the output register, so only PAY needs back-pressure.
    assign s_rdy    = (state != PAY) || !out_vld || m.TREADY;
    assign s_hs     = s.TVALID && s_rdy;
    assign s.TREADY = s_rdy;

    assign m.TVALID = out_vld;
    assign m.TDATA  = out_data;
    assign m.TKEEP  = out_keep;
    assign m.TLAST  = out_last;

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            state      <= HDR;
            remaining  <= '0;
            hdr_len    <= '0;
            hdr_src    <= '0;
            out_vld    <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            m_src_id   <= '0;
            m_len      <= '0;
            err_dst    <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            pkt_ok_cnt <= '0;
        end else begin
            err_dst   <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;

            if (out_vld && m.TREADY)
                out_vld <= 1'b0;

            case (state)
                HDR: begin
                    if (s_hs) begin
                        if ({f_dst_y, f_dst_x} != HsrcId) begin
                            err_dst <= 1'b1;
                            if (!s.TLAST)
                                state <= DRAIN;
                        end else if (f_len == '0) begin
                            if (s.TLAST) begin
                                if (pkt_ok_cnt != '1)
                                    pkt_ok_cnt <= pkt_ok_cnt + CNT_W'(1);
                            end else begin
                                err_long <= 1'b1;
                                state    <= DRAIN;
                            end
                        end else if (s.TLAST) begin
                            err_short <= 1'b1;
                        end else begin
                            // Sideband is staged here and only reaches m_* with the
                            // first payload flit, so a pending TLAST flit keeps its own.
                            hdr_src   <= f_src;
                            hdr_len   <= f_len;
                            remaining <= f_len;
                            state     <= PAY;
                        end
                    end
                end

                PAY: begin
                    if (s_hs) begin
                        out_vld   <= 1'b1;
                        out_data  <= s.TDATA;
                        out_keep  <= s.TKEEP;
                        m_src_id  <= hdr_src;
                        m_len     <= hdr_len;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            out_last <= 1'b1;
                            if (s.TLAST) begin
                                if (pkt_ok_cnt != '1)
                                    pkt_ok_cnt <= pkt_ok_cnt + CNT_W'(1);
                                state <= HDR;
                            end else begin
                                err_long <= 1'b1;
                                state    <= DRAIN;
                            end
                        end else begin
                            out_last <= s.TLAST;
                            if (s.TLAST) begin
                                err_short <= 1'b1;
                                state     <= HDR;
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (s_hs && s.TLAST)
                        state <= HDR;
                end

                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_local_rx_depacketizer.sv
// Randomised packet bench with a packet-level reference model and a per-cycle
// compare process for noc_local_rx_depacketizer.
module tb_noc_local_rx_depacketizer;

    localparam int BW = 32, BWB = 4, XY_SZ = 3, LEN_W = 16, CNT_W = 16;
    localparam logic [5:0] HSRC = 6'b010_011;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        bit          emit;
        bit          exp_last;
        int          err;      // 0 none, 1 dst, 2 short, 3 long
        bit          ok;
        logic [5:0]  src;
        logic [15:0] len;
    } desc_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [5:0]  src;
        logic [15:0] len;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  src_id_o;
    logic [15:0] len_o;
    logic        e_dst, e_short, e_long;
    logic [15:0] ok_cnt;

    noc_local_rx_depacketizer_if #(.BW(BW)) s_if ();
    noc_local_rx_depacketizer_if #(.BW(BW)) m_if ();

    noc_local_rx_depacketizer #(
        .BW(BW), .BWB(BWB), .XY_SZ(XY_SZ), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) dut (
        .clk_line        (clk),
        .clk_line_rst_low(rst_n),
        .HsrcId          (HSRC),
        .s               (s_if),
        .m               (m_if),
        .m_src_id        (src_id_o),
        .m_len           (len_o),
        .err_dst         (e_dst),
        .err_short       (e_short),
        .err_long        (e_long),
        .pkt_ok_cnt      (ok_cnt)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;
    bit    gaps = 1'b0;
    int    rdy_mode = 0;   // 0 always, 1 random, 2 pattern 1,0,0,1, 3 never
    desc_t dq[$];
    out_t  oq[$];
    int    pend_err = 0;
    bit    pend_emit = 1'b0, pend_hold = 1'b0;
    out_t  pend_o, held;
    int    exp_ok = 0;
    int    n_out = 0, n_last = 0, n_dst = 0, n_short = 0, n_long = 0;
    logic [5:0]  last_src;
    logic [15:0] last_len;
    int    first_in_cyc = -1, first_out_cyc = -1, last_out_cyc = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Downstream ready generator
    initial begin
        int idx;
        int pat[4];
        pat = '{1, 0, 0, 1};
        idx = 0;
        m_if.TREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_if.TREADY = 1'b1;
                1: m_if.TREADY = 1'($urandom_range(0, 1));
                2: begin m_if.TREADY = 1'(pat[idx]); idx = (idx + 1) % 4; end
                default: m_if.TREADY = 1'b0;
            endcase
        end
    end

    // Compare process: inputs change at posedge+1, everything sampled at negedge.
    always @(negedge clk) begin
        desc_t d;
        out_t  o;
        cyc++;
        if (mon_en) begin
            chk("err_dst", e_dst, pend_err == 1);
            chk("err_short", e_short, pend_err == 2);
            chk("err_long", e_long, pend_err == 3);
            chk("pkt_ok_cnt", ok_cnt, exp_ok[15:0]);
            if (pend_emit) begin
                chk("latency_vld", m_if.TVALID, 1'b1);
                chk("latency_data", m_if.TDATA, pend_o.data);
                chk("latency_last", m_if.TLAST, pend_o.last);
            end
            if (pend_hold) begin
                chk("hold_vld", m_if.TVALID, 1'b1);
                chk("hold_data", m_if.TDATA, held.data);
                chk("hold_keep", m_if.TKEEP, held.keep);
                chk("hold_last", m_if.TLAST, held.last);
                chk("hold_src", src_id_o, held.src);
                chk("hold_len", len_o, held.len);
            end
            n_dst   += int'(e_dst);
            n_short += int'(e_short);
            n_long  += int'(e_long);
            pend_err = 0; pend_emit = 1'b0; pend_hold = 1'b0;

            if (m_if.TVALID) begin
                if (oq.size() == 0) begin
                    chk("spurious_m_tvalid", m_if.TVALID, 1'b0);
                end else if (m_if.TREADY) begin
                    o = oq.pop_front();
                    chk("out_data", m_if.TDATA, o.data);
                    chk("out_keep", m_if.TKEEP, o.keep);
                    chk("out_last", m_if.TLAST, o.last);
                    chk("out_src", src_id_o, o.src);
                    chk("out_len", len_o, o.len);
                    n_out++;
                    if (m_if.TLAST) n_last++;
                    last_src = src_id_o;
                    last_len = len_o;
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                    last_out_cyc = cyc;
                end else begin
                    pend_hold = 1'b1;
                    held.data = m_if.TDATA; held.keep = m_if.TKEEP; held.last = m_if.TLAST;
                    held.src = src_id_o; held.len = len_o;
                end
            end

            if (s_if.TVALID) begin
                if (dq.size() == 0) begin
                    chk("unexpected_input", s_if.TVALID, 1'b0);
                end else begin
                    d = dq[0];
                    chk("s_tready", s_if.TREADY, d.emit ? !(m_if.TVALID && !m_if.TREADY) : 1'b1);
                    if (s_if.TREADY) begin
                        void'(dq.pop_front());
                        if (d.emit) begin
                            o.data = d.data; o.keep = d.keep; o.last = d.exp_last;
                            o.src = d.src; o.len = d.len;
                            oq.push_back(o);
                            pend_emit = 1'b1;
                            pend_o = o;
                            if (first_in_cyc < 0) first_in_cyc = cyc;
                        end
                        pend_err = d.err;
                        if (d.ok && exp_ok < 65535) exp_ok++;
                    end
                end
            end
        end
    end

    task automatic drive(input logic [31:0] data, input logic [3:0] keep, input logic last);
        int t;
        logic got;
        t = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            s_if.TVALID = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        s_if.TVALID = 1'b1;
        s_if.TDATA  = data;
        s_if.TKEEP  = keep;
        s_if.TLAST  = last;
        forever begin
            @(negedge clk);
            got = s_if.TREADY;
            @(posedge clk);
            #1;
            if (got) break;
            t++;
            if (t > 200) begin
                chk("input_handshake_timeout", got, 1'b1);
                break;
            end
        end
        s_if.TVALID = 1'b0;
    endtask

    // Packet-level reference model: what each input flit must cause.
    task automatic send_pkt(input logic [5:0] dst, input logic [5:0] src, input int len, input int npay);
        desc_t d;
        desc_t fl[$];
        logic [31:0] w;
        bit match;
        match = (dst == HSRC);
        w = $urandom;
        w[5:0] = dst; w[11:6] = src; w[31:16] = 16'(len);
        d.data = w; d.keep = 4'hF; d.last = (npay == 0);
        d.emit = 1'b0; d.exp_last = 1'b0; d.ok = 1'b0; d.err = 0;
        d.src = src; d.len = 16'(len);
        if (!match) d.err = 1;
        else if (len == 0) begin
            if (npay == 0) d.ok = 1'b1;
            else d.err = 3;
        end else if (npay == 0) d.err = 2;
        fl.push_back(d);
        for (int i = 1; i <= npay; i++) begin
            d.data = $urandom; d.keep = 4'($urandom); d.last = (i == npay);
            d.emit = match && len > 0 && i <= len;
            d.exp_last = d.emit && (i == len || i == npay);
            d.err = 0; d.ok = 1'b0;
            if (d.emit && i == npay && npay < len) d.err = 2;
            if (d.emit && i == len && npay > len) d.err = 3;
            if (d.emit && i == len && npay == len) d.ok = 1'b1;
            fl.push_back(d);
        end
        foreach (fl[i]) dq.push_back(fl[i]);
        foreach (fl[i]) drive(fl[i].data, fl[i].keep, fl[i].last);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((dq.size() + oq.size()) != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 1000) chk("drain_timeout", dq.size() + oq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_out, b_last, b_dst, b_short, b_long;
        logic [5:0] dst;
        int len, npay;
        logic [31:0] w;

        s_if.TVALID = 1'b0; s_if.TDATA = '0; s_if.TKEEP = '0; s_if.TLAST = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_m_tvalid", m_if.TVALID, 1'b0);
        chk("rst_m_tdata", m_if.TDATA, 32'h0);
        chk("rst_m_tlast", m_if.TLAST, 1'b0);
        chk("rst_m_tkeep", m_if.TKEEP, 4'h0);
        chk("rst_errs", {e_dst, e_short, e_long}, 3'b000);
        chk("rst_pkt_ok_cnt", ok_cnt, 16'h0);
        chk("rst_src_len", {src_id_o, len_o}, 22'h0);
        chk("rst_s_tready", s_if.TREADY, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Clean len=3 packet, full rate
        b_out = n_out; b_last = n_last; b_dst = n_dst; b_short = n_short; b_long = n_long;
        first_in_cyc = -1; first_out_cyc = -1;
        send_pkt(HSRC, 6'b001_000, 3, 3);
        drain();
        chk("t1_flits", n_out - b_out, 3);
        chk("t1_tlast", n_last - b_last, 1);
        chk("t1_src", last_src, 6'b001_000);
        chk("t1_len", last_len, 16'd3);
        chk("t1_ok_cnt", ok_cnt, 16'd1);
        chk("t1_first_latency", first_out_cyc - first_in_cyc, 1);
        chk("t1_back_to_back", last_out_cyc - first_out_cyc, 2);
        chk("t1_no_err", (n_dst - b_dst) + (n_short - b_short) + (n_long - b_long), 0);

        // Same packet under 1,0,0,1 back-pressure
        rdy_mode = 2;
        b_out = n_out;
        send_pkt(HSRC, 6'b001_000, 3, 3);
        drain();
        chk("t2_flits", n_out - b_out, 3);
        chk("t2_ok_cnt", ok_cnt, 16'd2);

        // Misaddressed packet
        rdy_mode = 0;
        b_out = n_out; b_dst = n_dst;
        send_pkt(6'b000_000, 6'b001_000, 4, 4);
        drain();
        chk("t3_err_dst", n_dst - b_dst, 1);
        chk("t3_no_out", n_out - b_out, 0);
        chk("t3_ok_cnt", ok_cnt, 16'd2);

        // Short packet then a normal one
        b_out = n_out; b_last = n_last; b_short = n_short;
        send_pkt(HSRC, 6'b000_001, 4, 2);
        drain();
        chk("t4_flits", n_out - b_out, 2);
        chk("t4_tlast", n_last - b_last, 1);
        chk("t4_err_short", n_short - b_short, 1);
        send_pkt(HSRC, 6'b000_010, 1, 1);
        drain();
        chk("t4_next_ok", ok_cnt, 16'd3);

        // Long packet: truncated at len, rest drained
        b_out = n_out; b_last = n_last; b_long = n_long;
        send_pkt(HSRC, 6'b011_001, 2, 5);
        drain();
        chk("t5_flits", n_out - b_out, 2);
        chk("t5_tlast", n_last - b_last, 1);
        chk("t5_err_long", n_long - b_long, 1);
        chk("t5_ok_cnt", ok_cnt, 16'd3);

        // Header-only packet
        b_out = n_out;
        send_pkt(HSRC, 6'b111_111, 0, 0);
        drain();
        chk("t6_ok_cnt", ok_cnt, 16'd4);
        chk("t6_no_out", n_out - b_out, 0);

        // Random traffic
        rdy_mode = 1;
        gaps = 1'b1;
        for (int p = 0; p < 200; p++) begin
            dst = ($urandom_range(0, 9) < 8) ? HSRC : 6'($urandom);
            len = $urandom_range(0, 5);
            npay = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 1) npay = len;
            send_pkt(dst, 6'($urandom), len, npay);
        end
        rdy_mode = 0;
        drain();

        // Reset in the middle of a payload with a flit stuck in the output register
        mon_en = 1'b0;
        gaps = 1'b0;
        rdy_mode = 3;
        w = 32'h0;
        w[5:0] = HSRC; w[11:6] = 6'b001_001; w[31:16] = 16'd3;
        drive(w, 4'hF, 1'b0);
        drive(32'hA5A5_0001, 4'hF, 1'b0);
        chk("mid_rst_pre_vld", m_if.TVALID, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", m_if.TVALID, 1'b0);
        chk("mid_rst_ok_cnt", ok_cnt, 16'd0);
        chk("mid_rst_s_tready", s_if.TREADY, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        dq.delete(); oq.delete();
        exp_ok = 0; pend_err = 0; pend_emit = 1'b0; pend_hold = 1'b0;
        mon_en = 1'b1;
        b_out = n_out;
        send_pkt(HSRC, 6'b001_000, 3, 3);
        drain();
        chk("post_rst_flits", n_out - b_out, 3);
        chk("post_rst_ok_cnt", ok_cnt, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_local_rx_depacketizer.md
Name: noc_local_rx_depacketizer

Overview:
- Sits between the tile switch local-out port and the accelerator stream input.
- Consumes NoC packets (one header flit plus payload flits), checks the destination against the tile's own coordinates, and strips the header.
- Forwards the payload as a clean AXI-Stream with stable source/length sideband.
- Enforces the header length field against TLAST, truncating or draining malformed packets and flagging each error.

Parameters:
- BW, 32, stream data width in bits (header format needs BW>=32).
- BWB, BW/8, TKEEP width.
- XY_SZ, 3, bits per X/Y coordinate.
- LEN_W, 16, width of the header payload-length field.
- CNT_W, 16, width of the packet statistics counters.

Ports:
- clk_line  in  1  line clock; all logic on rising edge.
- clk_line_rst_low  in  1  asynchronous, active-low reset.
- HsrcId  in  2*XY_SZ  own tile ID {Y,X}; quasi-static.
- s_TVALID  in  1  upstream flit valid (from switch local out).
- s_TDATA  in  BW  upstream flit data.
- s_TKEEP  in  BWB  upstream byte keep.
- s_TLAST  in  1  upstream end of packet.
- s_TREADY  out  1  upstream ready.
- m_TVALID  out  1  payload flit valid (to accelerator).
- m_TDATA  out  BW  payload data.
- m_TKEEP  out  BWB  payload keep.
- m_TLAST  out  1  last payload flit.
- m_TREADY  in  1  downstream ready.
- m_src_id  out  2*XY_SZ  source ID of current packet; stable from first payload flit to TLAST handshake.
- m_len  out  LEN_W  header length of current packet; stable like m_src_id.
- err_dst  out  1  one-cycle pulse: header destination != HsrcId.
- err_short  out  1  one-cycle pulse: TLAST before length exhausted.
- err_long  out  1  one-cycle pulse: length exhausted without TLAST.
- pkt_ok_cnt  out  CNT_W  count of packets delivered without error; saturates at all-ones.

Behaviour:
- Header flit fields:
  - [XY_SZ-1:0] dstX; [2*XY_SZ-1:XY_SZ] dstY.
  - [4*XY_SZ-1:2*XY_SZ] source ID {Y,X}.
  - [16+LEN_W-1:16] payload length in flits.
  - Other bits ignored.
- Reset (async assert, synchronous release): state HDR; all outputs 0; counters 0; m_src_id/m_len 0.
- Output stage is a single register.
  - Payload flit appears on m_* the cycle after its s_ handshake.
  - Full rate, one flit/cycle, when m_TREADY stays high.
  - m_* held stable while m_TVALID && !m_TREADY (AXI-Stream rules: no valid drop, no data change).
- s_TREADY:
  - HDR and DRAIN: 1, unconditionally.
  - PAY: (!m_TVALID || m_TREADY).
- State HDR, on header handshake:
  - dst != HsrcId: pulse err_dst; go to HDR if s_TLAST, else DRAIN.
  - len==0 and s_TLAST: pkt_ok_cnt++; stay HDR; nothing emitted.
  - len==0 and !s_TLAST: pulse err_long; go to DRAIN.
  - len>0 and s_TLAST: pulse err_short; stay HDR; nothing emitted.
  - Otherwise: latch m_src_id and m_len; remaining=len; go to PAY.
- State PAY, on each payload handshake:
  - Emit flit; remaining decrements.
  - remaining==1 and s_TLAST: m_TLAST=1; pkt_ok_cnt++; go to HDR.
  - remaining>1 and s_TLAST: m_TLAST=1; pulse err_short; go to HDR.
  - remaining==1 and !s_TLAST: force m_TLAST=1; pulse err_long; go to DRAIN.
- State DRAIN: accept and discard flits; on the s_TLAST handshake, go to HDR. No output.
- Error pulses are asserted in the cycle after the offending handshake.
- At most one error pulse per packet.
- A header arriving in HDR while the output register still holds the previous TLAST flit is accepted; the register is not overwritten, because only PAY writes it.
- Entering PAY while the previous TLAST flit is still pending gives s_TREADY=0 until it drains.
- TKEEP is passed through unmodified; no byte-level checks.
- Reset mid-packet: state returns to HDR and m_TVALID to 0 immediately. The partial packet is lost; upstream is responsible for resynchronisation.

Decomposition:
- Package noc_pkt_pkg holds:
  - header field offsets/widths (DST_X_LSB, DST_Y_LSB, SRC_LSB, LEN_LSB, LEN_W);
  - enum rx_state_t {HDR, PAY, DRAIN};
  - a function to extract header fields.
- No sub-module needed. The output register is inline; optionally factor it as noc_axis_reg_slice if the team reuses it elsewhere.

Test Plan:
- HsrcId=6'b010_011; header dst=(Y2,X3), src=(Y1,X0), len=3, then 3 payload flits with TLAST on the third, m_TREADY=1:
  - 3 flits out, back-to-back, first one cycle after its input;
  - m_TLAST on the third; m_src_id=6'b001_000; m_len=3; pkt_ok_cnt=1; no errors.
- Same packet with m_TREADY toggling 1,0,0,1,...: data/TLAST unchanged while stalled; s_TREADY low exactly when the output is full and not ready; all 3 flits are delivered in order.
- Header dst=(Y0,X0) with 4 payload flits: err_dst pulses once; s_TREADY=1 throughout; m_TVALID never asserts; pkt_ok_cnt unchanged.
- len=4 with TLAST on payload flit 2: 2 flits out, m_TLAST on the second, err_short one pulse, next header parsed normally.
- len=2 with TLAST on payload flit 5: 2 flits out with forced m_TLAST on the second, err_long pulses, flits 3-5 discarded, back to HDR.
- Header-only len=0 with TLAST gives pkt_ok_cnt+1 and no output. Also assert reset mid-PAY: m_TVALID=0 and state HDR; the next clean packet passes.
